// File: rtl/tty_pkg.sv
// tty_pkg: shared IOT opcode, default device codes, function codes and printer state type
package tty_pkg;
    localparam logic [2:0] IOT_OP      = 3'o6;
    localparam logic [5:0] KBD_DEV_DEF = 6'o03;
    localparam logic [5:0] PRN_DEV_DEF = 6'o04;
    localparam logic [2:0] FN_KCF      = 3'o0;
    localparam logic [2:0] FN_KSF      = 3'o1;
    localparam logic [2:0] FN_KCC      = 3'o2;
    localparam logic [2:0] FN_KRS      = 3'o4;
    localparam logic [2:0] FN_KRB      = 3'o6;
    localparam logic [2:0] FN_TFL      = 3'o0;
    localparam logic [2:0] FN_TSF      = 3'o1;
    localparam logic [2:0] FN_TCF      = 3'o2;
    localparam logic [2:0] FN_TPC      = 3'o4;
    localparam logic [2:0] FN_TLS      = 3'o6;
    typedef enum logic [1:0] {P_IDLE, P_SEND, P_WAIT} prn_state_e;
endpackage

// File: rtl/tty_printer_fsm.sv
// tty_printer_fsm: printer sink handshake plus post-handshake delay that pulses done
// Ports: clk/rst_n; start (print request), char_in (character to print), prn_ready (sink ready);
//        prn_valid/prn_char (sink handshake), done (one-cycle flag-set pulse), overrun (sticky)
module tty_printer_fsm
    import tty_pkg::*;
#(
    parameter int PRN_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] char_in,
    input  logic       prn_ready,
    output logic       prn_valid,
    output logic [7:0] prn_char,
    output logic       done,
    output logic       overrun
);
    prn_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] char_q, char_d;
    logic       ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P_IDLE;
            cnt_q   <= 8'd0;
            char_q  <= 8'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        done    = 1'b0;
        // A start that arrives while busy is dropped but remembered
        ovr_d   = ovr_q | (start && state_q != P_IDLE);
        case (state_q)
            P_IDLE: if (start) begin
                char_d  = char_in;
                state_d = P_SEND;
            end
            P_SEND: if (prn_ready) begin
                cnt_d   = PRN_DELAY[7:0];
                state_d = P_WAIT;
            end
            P_WAIT: if (cnt_q == 8'd1) begin
                done    = 1'b1;
                cnt_d   = 8'd0;
                state_d = P_IDLE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            default: state_d = P_IDLE;
        endcase
    end

    assign prn_valid = (state_q == P_SEND);
    assign prn_char  = char_q;
    assign overrun   = ovr_q;
endmodule

// File: rtl/tty_iot_unit.sv
// tty_iot_unit: teletype keyboard/printer IOT device with registered one-cycle response
// Ports: clock/resetN; iot_req/iot_ir/dataout (command from CPU); iot_ack/datain/iot_skip/
//        iot_clr_ac/iot_or_ac (response); kbd_valid/kbd_char/kbd_ready (keyboard source);
//        prn_valid/prn_char/prn_ready (printer sink); prn_overrun (sticky busy-start error)
module tty_iot_unit
    import tty_pkg::*;
#(
    parameter int         PRN_DELAY = 4,
    parameter logic [5:0] KBD_DEV   = KBD_DEV_DEF,
    parameter logic [5:0] PRN_DEV   = PRN_DEV_DEF
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        iot_req,
    input  logic [11:0] iot_ir,
    input  logic [7:0]  dataout,
    output logic        iot_ack,
    output logic [7:0]  datain,
    output logic        iot_skip,
    output logic        iot_clr_ac,
    output logic        iot_or_ac,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_char,
    output logic        kbd_ready,
    output logic        prn_valid,
    output logic [7:0]  prn_char,
    input  logic        prn_ready,
    output logic        prn_overrun
);
    logic       cmd, kbd_sel, prn_sel, kbd_acc, prn_done;
    logic [2:0] fn;
    logic       kbd_flag_q, kbd_flag_d, prn_flag_q, prn_flag_d;
    logic [7:0] kbd_buf_q, kbd_buf_d, datain_q, datain_d;
    logic       ack_q, ack_d, skip_q, skip_d, clr_q, clr_d, or_q, or_d;

    assign cmd     = iot_req && iot_ir[11:9] == IOT_OP;
    assign fn      = iot_ir[2:0];
    assign kbd_sel = cmd && iot_ir[8:3] == KBD_DEV;
    assign prn_sel = cmd && iot_ir[8:3] == PRN_DEV;
    assign kbd_acc = kbd_valid && !kbd_flag_q;

    tty_printer_fsm #(.PRN_DELAY(PRN_DELAY)) u_prn (
        .clk       (clock),
        .rst_n     (resetN),
        .start     (prn_sel && fn[2]),
        .char_in   (dataout),
        .prn_ready (prn_ready),
        .prn_valid (prn_valid),
        .prn_char  (prn_char),
        .done      (prn_done),
        .overrun   (prn_overrun)
    );

    // Function bits combine: bit0 skip on flag, bit1 clear AC (kbd) / clear flag,
    // bit2 read buffer (kbd) / start print; code 0 clears (kbd) or sets (prn) the flag.
    // Flag sets take priority over same-cycle clears.
    always_comb begin
        kbd_flag_d = kbd_acc | (kbd_flag_q & ~(kbd_sel && (fn == FN_KCF || fn[1])));
        kbd_buf_d  = kbd_acc ? kbd_char : kbd_buf_q;
        prn_flag_d = prn_done | (prn_sel && fn == FN_TFL) | (prn_flag_q & ~(prn_sel && fn[1]));
        ack_d      = cmd;
        skip_d     = fn[0] && ((kbd_sel && kbd_flag_q) || (prn_sel && prn_flag_q));
        clr_d      = kbd_sel && fn[1];
        or_d       = kbd_sel && fn[2];
        datain_d   = (kbd_sel && fn[2]) ? kbd_buf_q : 8'd0;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            kbd_flag_q <= 1'b0;
            kbd_buf_q  <= 8'd0;
            prn_flag_q <= 1'b0;
            ack_q      <= 1'b0;
            skip_q     <= 1'b0;
            clr_q      <= 1'b0;
            or_q       <= 1'b0;
            datain_q   <= 8'd0;
        end else begin
            kbd_flag_q <= kbd_flag_d;
            kbd_buf_q  <= kbd_buf_d;
            prn_flag_q <= prn_flag_d;
            ack_q      <= ack_d;
            skip_q     <= skip_d;
            clr_q      <= clr_d;
            or_q       <= or_d;
            datain_q   <= datain_d;
        end
    end

    assign kbd_ready  = !kbd_flag_q;
    assign iot_ack    = ack_q;
    assign iot_skip   = skip_q;
    assign iot_clr_ac = clr_q;
    assign iot_or_ac  = or_q;
    assign datain     = datain_q;
endmodule

// File: tb/tb_tty_iot_unit.sv
// tb_tty_iot_unit: scoreboard bench with a behavioural model of the teletype IOT device
module tb_tty_iot_unit;
    localparam int         D   = 4;
    localparam logic [5:0] KBD = 6'o03;
    localparam logic [5:0] PRN = 6'o04;

    logic        clock = 1'b0, resetN = 1'b0;
    logic        iot_req = 1'b0, kbd_valid = 1'b0, prn_ready = 1'b0;
    logic [11:0] iot_ir = 12'd0;
    logic [7:0]  dataout = 8'd0, kbd_char = 8'd0;
    logic        iot_ack, iot_skip, iot_clr_ac, iot_or_ac, kbd_ready, prn_valid, prn_overrun;
    logic [7:0]  datain, prn_char;

    tty_iot_unit #(.PRN_DELAY(D), .KBD_DEV(KBD), .PRN_DEV(PRN)) dut (
        .clock(clock), .resetN(resetN), .iot_req(iot_req), .iot_ir(iot_ir), .dataout(dataout),
        .iot_ack(iot_ack), .datain(datain), .iot_skip(iot_skip), .iot_clr_ac(iot_clr_ac),
        .iot_or_ac(iot_or_ac), .kbd_valid(kbd_valid), .kbd_char(kbd_char), .kbd_ready(kbd_ready),
        .prn_valid(prn_valid), .prn_char(prn_char), .prn_ready(prn_ready), .prn_overrun(prn_overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic       skip;
        logic       clr;
        logic       orr;
        logic [7:0] data;
    } resp_t;
    resp_t q[$];

    int checks = 0, errors = 0, cyc = 0;

    // Model state: values expected after the next clock edge
    logic       m_kflag = 0, m_pflag = 0, m_busy = 0, m_sending = 0, m_ovr = 0;
    logic [7:0] m_kbuf = 0, m_pchar = 0;
    int         m_due = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_kflag = 0; m_pflag = 0; m_busy = 0; m_sending = 0; m_ovr = 0;
        m_kbuf = 0; m_pchar = 0; m_due = -1;
        q.delete();
    endtask

    task automatic step(input logic req, input logic [11:0] ir, input logic [7:0] dout,
                        input logic kv, input logic [7:0] kc, input logic pr);
        logic       cmd, kacc, done, busy_old, ksel, psel;
        logic [2:0] fn;
        resp_t      r;
        @(negedge clock);
        iot_req = req; iot_ir = ir; dataout = dout; kbd_valid = kv; kbd_char = kc; prn_ready = pr;
        cmd  = req && ir[11:9] == 3'o6;
        fn   = ir[2:0];
        ksel = cmd && ir[8:3] == KBD;
        psel = cmd && ir[8:3] == PRN;
        kacc = kv && !m_kflag;
        if (cmd) begin
            r.due  = cyc + 1;
            r.skip = fn[0] && ((ksel && m_kflag) || (psel && m_pflag));
            r.clr  = ksel && fn[1];
            r.orr  = ksel && fn[2];
            r.data = (ksel && fn[2]) ? m_kbuf : 8'd0;
            q.push_back(r);
        end
        if (kacc) m_kbuf = kc;
        m_kflag  = kacc ? 1'b1 : (ksel && (fn == 3'o0 || fn[1])) ? 1'b0 : m_kflag;
        busy_old = m_busy;
        done     = m_busy && !m_sending && (cyc + 1 == m_due);
        if (m_sending && pr) begin
            m_sending = 0;
            m_due     = cyc + 1 + D;
        end
        if (done) m_busy = 0;
        if (psel && fn[2]) begin
            if (busy_old) m_ovr = 1;
            else begin
                m_busy = 1; m_sending = 1; m_pchar = dout;
            end
        end
        m_pflag = (done || (psel && fn == 3'o0)) ? 1'b1 : (psel && fn[1]) ? 1'b0 : m_pflag;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 12'd0, 8'd0, 0, 8'd0, 0);
    endtask

    // Monitor: checks the response channel and the continuously visible outputs after each edge
    initial begin
        forever begin
            logic exp_ack;
            resp_t r;
            @(posedge clock);
            #1;
            cyc++;
            exp_ack = q.size() > 0 && q[0].due == cyc;
            chk("ack", iot_ack, exp_ack);
            if (exp_ack) begin
                r = q.pop_front();
                chk("skip", iot_skip, r.skip);
                chk("clr_ac", iot_clr_ac, r.clr);
                chk("or_ac", iot_or_ac, r.orr);
                chk("datain", datain, r.data);
            end else begin
                chk("idle_resp", {iot_skip, iot_clr_ac, iot_or_ac, datain}, 0);
            end
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            chk("kbd_ready", kbd_ready, !m_kflag);
            chk("prn_valid", prn_valid, m_sending);
            chk("prn_char", prn_char, m_pchar);
            chk("prn_overrun", prn_overrun, m_ovr);
        end
    end

    initial begin
        logic [5:0] dev;
        repeat (2) @(negedge clock);
        resetN = 1;
        // keyboard accept, skip, read-and-clear, skip again
        step(0, 12'd0, 8'd0, 1, 8'h41, 0);
        idle(1);
        step(1, 12'o6031, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6036, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6031, 8'd0, 0, 8'd0, 0);
        idle(2);
        // accept coincident with KCF: set wins
        step(1, 12'o6030, 8'd0, 1, 8'h77, 0);
        step(1, 12'o6031, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6034, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6032, 8'd0, 0, 8'd0, 0);
        idle(1);
        // TLS, stalled sink, then busy TPC overrun during the wait
        step(1, 12'o6046, 8'h5A, 0, 8'd0, 0);
        step(0, 12'd0, 8'd0, 0, 8'd0, 0);
        step(0, 12'd0, 8'd0, 0, 8'd0, 0);
        step(0, 12'd0, 8'd0, 0, 8'd0, 0);
        step(0, 12'd0, 8'd0, 0, 8'd0, 1);
        step(1, 12'o6044, 8'h33, 0, 8'd0, 0);
        step(1, 12'o6041, 8'd0, 0, 8'd0, 0);
        idle(2);
        step(1, 12'o6041, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6042, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6041, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6040, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6041, 8'd0, 0, 8'd0, 0);
        // unknown device and non-IOT opcode
        step(1, 12'o6101, 8'd0, 0, 8'd0, 0);
        step(1, 12'o1234, 8'd0, 0, 8'd0, 0);
        idle(2);
        // reset while the printer is presenting a character
        step(1, 12'o6044, 8'hC3, 0, 8'd0, 0);
        step(1, 12'o6031, 8'd0, 0, 8'd0, 0);
        @(negedge clock);
        iot_req = 0; kbd_valid = 0; prn_ready = 0;
        #2 resetN = 0;
        #1;
        chk("rst_prn_valid", prn_valid, 0);
        chk("rst_prn_char", prn_char, 0);
        chk("rst_ack", {iot_ack, iot_skip, iot_clr_ac, iot_or_ac, datain}, 0);
        chk("rst_kbd_ready", kbd_ready, 1);
        chk("rst_overrun", prn_overrun, 0);
        model_reset();
        @(negedge clock);
        resetN = 1;
        step(1, 12'o6041, 8'd0, 0, 8'd0, 0);
        step(1, 12'o6031, 8'd0, 0, 8'd0, 0);
        idle(1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    dev = KBD;
                2:       dev = PRN;
                default: dev = 6'($urandom);
            endcase
            step($urandom_range(0, 2) != 0,
                 ($urandom_range(0, 9) == 0) ? 12'($urandom) : {3'o6, dev, 3'($urandom)},
                 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
        end
        idle(3);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tty_iot_unit.md
TTY_IOT_UNIT -- requirements
Module: tty_iot_unit

Interface
REQ-001 SHALL have parameter PRN_DELAY, default 4, meaning cycles from printer character accept to printer flag set (range 1-255).
REQ-002 SHALL have parameter KBD_DEV, default 6'o03, meaning keyboard device code.
REQ-003 SHALL have parameter PRN_DEV, default 6'o04, meaning printer device code.
REQ-004 SHALL have ports: clock in 1 (rising-edge clock); resetN in 1 (reset, asynchronous, active-low).
REQ-005 SHALL have ports: iot_req in 1 (one-cycle IOT strobe from controller); iot_ir in 12 (instruction word); dataout in 8 (AC[7:0] from CPU).
REQ-006 SHALL have ports: iot_ack out 1 (response valid); datain out 8 (to CPU OR-path); iot_skip out 1; iot_clr_ac out 1; iot_or_ac out 1.
REQ-007 SHALL have ports: kbd_valid in 1; kbd_char in 8; kbd_ready out 1 (keyboard source handshake).
REQ-008 SHALL have ports: prn_valid out 1; prn_char out 8; prn_ready in 1 (printer sink handshake); prn_overrun out 1 (sticky).

Function
REQ-009 SHALL decode a command only when iot_req=1 and iot_ir[11:9]=3'o6; device=iot_ir[8:3], function=iot_ir[2:0].
REQ-010 SHALL assert iot_ack exactly one cycle after an accepted command, for one cycle, with iot_skip/iot_clr_ac/iot_or_ac/datain valid in that cycle only, zero otherwise.
REQ-011 SHALL ack unknown devices with skip, clr, or all 0.
REQ-012 Keyboard: kbd_ready = !kbd_flag; kbd_valid&kbd_ready loads kbd_buf<=kbd_char and sets kbd_flag.
REQ-013 Keyboard functions: 0 KCF clear flag; 1 KSF skip=kbd_flag; 2 KCC clr_ac, clear flag; 4 KRS or_ac, datain=kbd_buf; 6 KRB clr_ac, or_ac, datain=kbd_buf, clear flag; other codes: OR of their bit actions.
REQ-014 Same-cycle flag set (keyboard accept) and KCF/KCC/KRB clear: set wins; skip samples flag before the edge.
REQ-015 Printer functions: 0 TFL set flag; 1 TSF skip=prn_flag; 2 TCF clear flag; 4 TPC start print of dataout; 6 TLS clear flag and start print.
REQ-016 Printer FSM states P_IDLE, P_SEND, P_WAIT; start in P_IDLE latches prn_char<=dataout, goes P_SEND.
REQ-017 P_SEND drives prn_valid=1, holds prn_char stable until prn_ready=1, then loads counter with PRN_DELAY and goes P_WAIT.
REQ-018 P_WAIT decrements counter; at count 1 sets prn_flag, returns P_IDLE (flag set exactly PRN_DELAY cycles after handshake edge).
REQ-019 Start while not P_IDLE SHALL not alter prn_char or state, SHALL set prn_overrun; flag-clear part of TLS still applies.
REQ-020 Flag set from P_WAIT completion and same-cycle TCF/TLS clear: set wins.

Reset
REQ-021 resetN=0 SHALL asynchronously force: kbd_flag=0, kbd_buf=0, prn_flag=0, prn_char=0, FSM=P_IDLE, counter=0, prn_overrun=0, iot_ack=0, datain=0, iot_skip=0, iot_clr_ac=0, iot_or_ac=0, prn_valid=0; kbd_ready=1.
REQ-022 Reset mid-print SHALL abandon the character; pending ack SHALL be lost.

Structure
REQ-023 Shared package tty_pkg SHALL hold IOT opcode constant, default device codes, function-code constants, printer state enum.
REQ-024 Printer FSM and delay counter SHALL be sub-module tty_printer_fsm; decode, keyboard and response registers stay in top.

Verification
REQ-025 kbd_char=8'h41 accepted, then KSF 6031 -> ack skip=1; KRB 6036 -> clr=1, or=1, datain=8'h41; next KSF -> skip=0, kbd_ready=1.
REQ-026 dataout=8'h5A, TLS 6046, prn_ready held 0 for 3 cycles -> prn_valid high 4 cycles, prn_char=8'h5A; flag set 4 cycles after handshake; TSF -> skip=1.
REQ-027 TPC 6044 during P_WAIT with dataout=8'h33 -> prn_char unchanged, prn_overrun=1, flag timing unchanged.
REQ-028 kbd_valid accept in same cycle as KCF -> kbd_flag=1 afterwards; KSF -> skip=1.
REQ-029 IOT 6101 (device 10) -> ack one cycle later, all responses 0; non-IOT 1234 with iot_req -> no ack.
REQ-030 resetN low during P_SEND -> prn_valid=0 immediately, all REQ-021 values; after release TSF -> skip=0.
